// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-expansion engine: key-size derivations,
// Rcon handling, GF(2^8) helpers, the forward S-box function and FSM states.
package aes_key_pkg;

   localparam int unsigned WORD_BITS  = 32;
   localparam int unsigned BLOCK_BITS = 128;
   localparam int unsigned IDX_BITS   = 4;
   localparam logic [7:0]  RCON_INIT  = 8'h01;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Number of 32-bit words in the cipher key.
   function automatic int unsigned nk_of(input int unsigned key_bits);
      return key_bits / WORD_BITS;
   endfunction

   // Number of cipher rounds for the given key size.
   function automatic int unsigned nr_of(input int unsigned key_bits);
      return nk_of(key_bits) + 6;
   endfunction

   // Multiply by x in GF(2^8), reduction polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply by shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse (x^254, with 0 -> 0) then affine map.
   function automatic logic [7:0] sbox_fn(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   in_byte : byte to substitute
//   sub_c   : substituted byte
module aes_sbox
   import aes_key_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] sub_c
);

   assign sub_c = sbox_fn(in_byte);

endmodule

// File: rtl/key_sched_step.sv
// One key-schedule step: derives the next four expanded words from the
// sliding window of the most recent Nk words.
//   window   : last Nk words, oldest word in the MSBs
//   rcon     : current round constant
//   rot_rcon : 1 = RotWord+SubWord+Rcon step, 0 = SubWord-only step
//   words_c  : four new words, first new word in the MSBs
module key_sched_step
   import aes_key_pkg::*;
#(
   parameter int unsigned KEY_BITS = 128
) (
   input  logic [KEY_BITS-1:0]   window,
   input  logic [7:0]            rcon,
   input  logic                  rot_rcon,
   output logic [BLOCK_BITS-1:0] words_c
);

   localparam int unsigned NK = nk_of(KEY_BITS);

   logic [WORD_BITS-1:0] last_word;
   logic [WORD_BITS-1:0] sub_in;
   logic [WORD_BITS-1:0] sub_out;
   logic [WORD_BITS-1:0] chain [5];

   assign last_word = window[WORD_BITS-1:0];
   assign sub_in    = rot_rcon ? {last_word[23:0], last_word[31:24]} : last_word;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte (sub_in[8*b +: 8]),
         .sub_c   (sub_out[8*b +: 8])
      );
   end

   // Only the first new word sees f(); the other three chain off their predecessor.
   assign chain[0] = sub_out ^ (rot_rcon ? {rcon, 24'h000000} : 32'h0);

   for (genvar k = 0; k < 4; k++) begin : g_chain
      assign chain[k+1] = window[KEY_BITS-1-WORD_BITS*k -: WORD_BITS] ^ chain[k];
      assign words_c[BLOCK_BITS-1-WORD_BITS*k -: WORD_BITS] = chain[k+1];
   end

   // With Nk=8 the middle three window words are not needed for this step.
   if (NK == 8) begin : g_nk8
      logic unused_mid;
      assign unused_mid = ^window[KEY_BITS-BLOCK_BITS-1:WORD_BITS];
   end

endmodule

// File: rtl/key_expansion_engine.sv
// AES key-expansion engine: streams round keys 0..Nr with valid/ready flow.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin an expansion (honoured only in IDLE)
//   key_in   : cipher key, word 0 in the MSBs
//   busy     : expansion in progress up to the final beat
//   rk_valid : rk_out/rk_idx carry a round key
//   rk_ready : consumer accepts the current beat
//   rk_out   : round key, first word in the MSBs
//   rk_idx   : round-key index
//   done     : one-cycle pulse after the final beat is accepted
module key_expansion_engine
   import aes_key_pkg::*;
#(
   parameter int unsigned KEY_BITS = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KEY_BITS-1:0]   key_in,
   output logic                  busy,
   output logic                  rk_valid,
   input  logic                  rk_ready,
   output logic [BLOCK_BITS-1:0] rk_out,
   output logic [IDX_BITS-1:0]   rk_idx,
   output logic                  done
);

   localparam int unsigned        NK       = nk_of(KEY_BITS);
   localparam int unsigned        NR       = nr_of(KEY_BITS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NR);

   if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("key_expansion_engine: KEY_BITS must be 128 or 256");
   end

   state_t                state, state_d;
   logic [KEY_BITS-1:0]   window, window_d;
   logic [7:0]            rcon, rcon_d;
   logic [BLOCK_BITS-1:0] rk_out_d;
   logic [IDX_BITS-1:0]   rk_idx_d;
   logic                  rk_valid_d;
   logic                  busy_d;
   logic                  done_d;

   logic                  accept;
   logic                  rot_rcon;
   logic                  split_half;
   logic [BLOCK_BITS-1:0] step_words;
   logic [KEY_BITS-1:0]   window_shift_c;

   assign accept = rk_valid & rk_ready;

   // Nk=8 alternates Rcon steps (even next index) with SubWord-only steps.
   assign rot_rcon   = (NK == 4) ? 1'b1 : rk_idx[0];
   // Nk=8 emits the lower key half as index 1 without computing anything.
   assign split_half = (NK == 8) && (rk_idx == '0);

   key_sched_step #(.KEY_BITS(KEY_BITS)) u_step (
      .window   (window),
      .rcon     (rcon),
      .rot_rcon (rot_rcon),
      .words_c  (step_words)
   );

   // Window after a step: drop the oldest four words, append the new four.
   if (NK == 4) begin : g_win4
      assign window_shift_c = step_words;
   end else begin : g_win8
      assign window_shift_c = {window[BLOCK_BITS-1:0], step_words};
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         window   <= '0;
         rcon     <= RCON_INIT;
         rk_out   <= '0;
         rk_idx   <= '0;
         rk_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         window   <= window_d;
         rcon     <= rcon_d;
         rk_out   <= rk_out_d;
         rk_idx   <= rk_idx_d;
         rk_valid <= rk_valid_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state;
      window_d   = window;
      rcon_d     = rcon;
      rk_out_d   = rk_out;
      rk_idx_d   = rk_idx;
      rk_valid_d = rk_valid;
      busy_d     = busy;
      done_d     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               window_d   = key_in;
               rcon_d     = RCON_INIT;
               rk_out_d   = key_in[KEY_BITS-1 -: BLOCK_BITS];
               rk_idx_d   = '0;
               rk_valid_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            if (!rk_valid) begin
               // Drain cycle while done is high; start is not sampled here.
               state_d = IDLE;
            end else if (accept) begin
               if (rk_idx == LAST_IDX) begin
                  rk_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  rk_idx_d = rk_idx + IDX_BITS'(1);
                  if (split_half) begin
                     rk_out_d = window[BLOCK_BITS-1:0];
                  end else begin
                     rk_out_d = step_words;
                     window_d = window_shift_c;
                     if (rot_rcon) rcon_d = xtime(rcon);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/key_expansion_engine.md
KEY_EXPANSION_ENGINE -- requirements
Module: key_expansion_engine

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, AES cipher-key width; legal values 128 and 256 only; any other value is an elaboration error.
REQ-002 SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new expansion; sampled only in IDLE.
REQ-006 key_in  input  KEY_BITS  cipher key, word 0 in the MSBs; captured on the accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the final round-key beat.
REQ-008 rk_valid  output  1  rk_out/rk_idx hold a valid round key.
REQ-009 rk_ready  input  1  consumer accepts the beat when rk_valid and rk_ready are both high.
REQ-010 rk_out  output  128  round key, word 4i in the MSBs.
REQ-011 rk_idx  output  4  round-key index i, 0..Nr.
REQ-012 done  output  1  one-cycle pulse in the cycle after the final beat is accepted.

Function
REQ-013 Nk = KEY_BITS/32 (4 or 8); Nr = 10 or 14; the block SHALL emit Nr+1 round keys, idx 0..Nr, strictly in order.
REQ-014 FSM states:
  - IDLE: start=1 captures key_in and goes to RUN.
  - RUN: emits beats; when the idx-Nr beat is accepted, goes to IDLE and pulses done.
REQ-015 Latency: rk_valid SHALL rise exactly one cycle after the accepted start, with idx 0.
REQ-016 Throughput: with rk_ready held high, one beat per cycle, i.e. Nr+1 consecutive cycles.
REQ-017 Backpressure: while rk_valid=1 and rk_ready=0, rk_out and rk_idx SHALL hold stable and internal state SHALL NOT advance.
REQ-018 Key storage: a KEY_BITS-wide sliding window holds the most recent Nk words.
  - Next 4 words: w[j] = w[j-Nk] xor f(w[j-1]).
  - f = SubWord(RotWord) xor Rcon when j mod Nk == 0.
  - f = SubWord only when Nk=8 and j mod 8 == 4.
  - f = identity otherwise.
REQ-019 KEY_BITS=128: idx 0 = key_in; each later beat computes 4 new words.
REQ-020 KEY_BITS=256: idx 0 and idx 1 = the upper and lower key halves, with no computation; idx>=2 computes 4 new words.
REQ-021 Rcon SHALL be held in an 8-bit register, initialised to 0x01 at start and advanced by GF(2^8) doubling (xtime, reduction 0x1b) only after an Rcon-consuming step; sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-022 start asserted while busy SHALL be ignored: no restart, no key recapture.
REQ-023 start and done in the same cycle: start is ignored, because the FSM is still in RUN.
REQ-024 rk_ready asserted while rk_valid=0 has no effect.
REQ-025 All outputs SHALL be registered; rk_out has no combinational path from key_in or rk_ready.

Reset
REQ-026 rst SHALL take precedence over every input, including mid-expansion; the next edge forces IDLE.
REQ-027 Reset values: rk_valid=0, busy=0, done=0, rk_idx=0, rk_out=0, Rcon register=0x01, key window=0.
REQ-028 After rst deasserts, no beat is emitted until a new start.

Structure
REQ-029 Shared package aes_key_pkg SHALL hold:
  - the Nk/Nr derivation functions;
  - the Rcon initial value and the xtime function;
  - the FSM state typedef {IDLE, RUN}.
REQ-030 One combinational sub-module, key_sched_step, SHALL compute the 4 new words from the window, Rcon and the step type, using four instances of the team's forward S-box; the FSM, window and Rcon stay in the top module.

Verification
REQ-031 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle after idx10, 11 beats total.
REQ-032 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx2 9ba354118e6925afa51a8b5f2067fcde, idx14 fe4890d1e6188d0b046df344706c631e, 15 beats total.
REQ-033 Random rk_ready stalls (about 50% duty) on the REQ-031 key -> identical ordered sequence; rk_out stable across every stall cycle.
REQ-034 start pulsed at idx 4 of a running expansion with a different key_in -> sequence unaffected; no restart.
REQ-035 rst asserted at idx 5 for one cycle -> next cycle rk_valid=0, busy=0; a following start with the REQ-031 key yields a clean idx 0..10.
REQ-036 Back-to-back: start in the cycle after done -> rk_valid is high two cycles after done, idx 0 = new key.
